// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame sequencer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
        StFlush,
        StDrop,
        StIfg
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned LEN_LSB       = 0;
    localparam int unsigned LEN_W         = 16;

    // 17-bit so that a 0xFFFF length cannot overflow.
    function automatic logic [16:0] words_for_len(input logic [16:0] len);
        return (len + 17'd3) >> 2;
    endfunction

endpackage

// File: rtl/eth_tx_word_unpack.sv
// Selects payload bytes LSB-first out of the FIFO head word.
module eth_tx_word_unpack (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        advance,
    input  logic [31:0] word,
    output logic [7:0]  tx_byte,
    output logic [1:0]  byte_idx,
    output logic        last_byte
);

    logic [1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            idx_q <= 2'd0;
        end else if (advance) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        unique case (idx_q)
            2'd0: tx_byte = word[7:0];
            2'd1: tx_byte = word[15:8];
            2'd2: tx_byte = word[23:16];
            2'd3: tx_byte = word[31:24];
        endcase
    end

    assign byte_idx  = idx_q;
    assign last_byte = (idx_q == 2'd3);

endmodule

// File: rtl/eth_tx_frame_sequencer.sv
// Moves length-prefixed frames from the 32-bit TX FIFO onto the byte-wide MAC TX pins,
// adding preamble/SFD, enforcing the inter-frame gap and aborting cleanly on underrun.
module eth_tx_frame_sequencer
    import eth_tx_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MAX_FL     = 1518,
    parameter int unsigned PRE_LEN    = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_en,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  MTxD,
    output logic        MTxEn,
    output logic        MTxErr,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        len_err,
    output logic [15:0] frame_cnt
);

    localparam logic [16:0] MaxLen  = 17'(MAX_FL);
    localparam logic [15:0] PreLast = 16'(PRE_LEN);
    // IFG state lasts IFG_CYCLES+1 cycles so the pin-level gap is IFG_CYCLES+2 idle bytes.
    localparam logic [15:0] IfgLast = 16'(IFG_CYCLES);

    tx_state_e   state_q, state_d;
    logic [16:0] cnt_q, cnt_d;        // bytes left in DATA, words left in FLUSH/DROP
    logic [15:0] phase_q, phase_d;    // preamble index in PRE, gap counter in IFG
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txerr_q, txerr_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        len_err_q, len_err_d;

    logic        rd_req;
    logic        unpack_adv;
    logic [7:0]  data_byte;
    logic [1:0]  byte_idx;
    logic        last_byte;
    logic [16:0] desc_len;

    assign desc_len = {1'b0, fifo_data[LEN_LSB +: LEN_W]};

    eth_tx_word_unpack u_unpack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state_q != StData),
        .advance   (unpack_adv),
        .word      (fifo_data),
        .tx_byte   (data_byte),
        .byte_idx  (byte_idx),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        rd_req      = 1'b0;
        unpack_adv  = 1'b0;
        txd_d       = 8'h00;
        txen_d      = 1'b0;
        txerr_d     = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        len_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_en && !fifo_empty) begin
                    rd_req = 1'b1;
                    cnt_d  = desc_len;
                    if (desc_len == 17'd0) begin
                        state_d = StIdle;
                    end else if (desc_len > MaxLen) begin
                        len_err_d = 1'b1;
                        cnt_d     = words_for_len(desc_len);
                        state_d   = StDrop;
                    end else begin
                        phase_d = 16'd0;
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                txen_d = 1'b1;
                if (phase_q == PreLast) begin
                    txd_d   = SFD_BYTE;
                    state_d = StData;
                end else begin
                    txd_d   = PREAMBLE_BYTE;
                    phase_d = phase_q + 16'd1;
                end
            end
            StData: begin
                txen_d = 1'b1;
                if (byte_idx == 2'd0 && fifo_empty) begin
                    // Next word missing: poison this byte and discard the rest of the frame.
                    txerr_d    = 1'b1;
                    underrun_d = 1'b1;
                    cnt_d      = words_for_len(cnt_q);
                    state_d    = StFlush;
                end else begin
                    txd_d      = data_byte;
                    unpack_adv = 1'b1;
                    cnt_d      = cnt_q - 17'd1;
                    rd_req     = last_byte || (cnt_q == 17'd1);
                    if (cnt_q == 17'd1) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        phase_d     = 16'd0;
                        state_d     = StIfg;
                    end
                end
            end
            StFlush, StDrop: begin
                if (!fifo_empty) begin
                    rd_req = 1'b1;
                    cnt_d  = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) begin
                        phase_d = 16'd0;
                        state_d = StIfg;
                    end
                end
            end
            StIfg: begin
                if (phase_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 17'd0;
            phase_q     <= 16'd0;
            frame_cnt_q <= 16'd0;
            txd_q       <= 8'h00;
            txen_q      <= 1'b0;
            txerr_q     <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            txd_q       <= txd_d;
            txen_q      <= txen_d;
            txerr_q     <= txerr_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            len_err_q   <= len_err_d;
        end
    end

    assign fifo_rd_en = rd_req && !fifo_empty && reset_n;
    assign busy       = (state_q != StIdle);
    assign MTxD       = txd_q;
    assign MTxEn      = txen_q;
    assign MTxErr     = txerr_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;
    assign len_err    = len_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
// Self-checking bench: FIFO model feeds the sequencer, a pin monitor records the byte
// stream, and each scenario compares it against bytes rebuilt from the frame contents.
module tb_eth_tx_frame_sequencer;

    localparam int IFG = 12;
    localparam int MAXL = 1518;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_en = 1'b0;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  MTxD;
    logic        MTxEn;
    logic        MTxErr;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        len_err;
    logic [15:0] frame_cnt;

    eth_tx_frame_sequencer #(
        .IFG_CYCLES (IFG),
        .MAX_FL     (MAXL),
        .PRE_LEN    (7)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_en      (tx_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .MTxD       (MTxD),
        .MTxEn      (MTxEn),
        .MTxErr     (MTxErr),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .len_err    (len_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // FIFO model (first-word-fall-through)
    logic [31:0] fq[$];
    int cyc = 0, pops = 0, rd_bad = 0, first_pop_cyc = -1;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) rd_bad++;
            else void'(fq.pop_front());
            if (pops == 0) first_pop_cyc = cyc;
            pops++;
        end
        cyc++;
        fifo_empty <= (fq.size() == 0);
        fifo_data  <= (fq.size() != 0) ? fq[0] : 32'h0;
    end

    // Pin monitor
    logic [8:0] obs[$];
    int done_pos[$];
    int gaps[$];
    int und_cnt = 0, lerr_cnt = 0, inv_bad = 0, zero_run = 0, first_en_cyc = -1;
    bit seen = 1'b0;

    always @(negedge clk) begin
        if (MTxEn) begin
            if (seen && zero_run > 0) gaps.push_back(zero_run);
            if (!seen) first_en_cyc = cyc;
            seen = 1'b1;
            zero_run = 0;
            obs.push_back({MTxErr, MTxD});
            if (frame_done) done_pos.push_back(obs.size() - 1);
        end else begin
            zero_run++;
            if (MTxD != 8'h00 || MTxErr || frame_done) inv_bad++;
        end
        if (underrun) begin
            und_cnt++;
            if (!(MTxEn && MTxErr && MTxD == 8'h00)) inv_bad++;
        end
        if (MTxErr && !underrun) inv_bad++;
        if (len_err) lerr_cnt++;
    end

    // Reference model: expected pin bytes {err, data} and last-byte positions
    logic [8:0]  exp_q[$];
    int          exp_done[$];
    logic [31:0] stage[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        obs.delete(); done_pos.delete(); gaps.delete();
        exp_q.delete(); exp_done.delete(); stage.delete();
        und_cnt = 0; lerr_cnt = 0; inv_bad = 0; zero_run = 0;
        seen = 1'b0; pops = 0; rd_bad = 0; first_pop_cyc = -1; first_en_cyc = -1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tx_en = 1'b0;
        tick(); tick();
        fq.delete();
        tick();
        reset_n = 1'b1;
        clear_mon();
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < (len + 3) / 4; i++) stage.push_back($urandom());
    endtask

    // Queue descriptor + staged words; good frames add preamble, SFD, payload to the model.
    task automatic queue_frame(input int len);
        logic [31:0] desc;
        desc = {16'($urandom()), 16'(len)};
        fq.push_back(desc);
        foreach (stage[i]) fq.push_back(stage[i]);
        if (len > 0 && len <= MAXL) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
            exp_q.push_back(9'h0D5);
            for (int k = 0; k < len; k++)
                exp_q.push_back({1'b0, 8'(stage[k / 4] >> (8 * (k % 4)))});
            exp_done.push_back(exp_q.size() - 1);
        end
        stage.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            tick();
            n++;
            if (!busy && fq.size() == 0 && fifo_empty) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 4) $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, n);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tx_en = 1'b1;
        fq.push_back(32'h0000_0004);
        tick(); tick(); tick();
        checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en);
        else passed++;
        checks++;
        if ({MTxEn, MTxErr, MTxD} !== 10'h000)
            $display("FAIL reset_pins: got en=%b err=%b d=%h required 0", MTxEn, MTxErr, MTxD);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else passed++;
        checks++;
        if (frame_cnt !== 16'h0) $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
        else passed++;
        checks++;
        if ({frame_done, underrun, len_err} !== 3'b000)
            $display("FAIL reset_pulses: got %b required 000", {frame_done, underrun, len_err});
        else passed++;
        tx_en = 1'b0;
        fq.delete();
    endtask

    task automatic test_basic();
        do_reset();
        stage.push_back(32'h4433_2211);
        stage.push_back(32'h0000_00AA);
        queue_frame(5);
        tx_en = 1'b1;
        wait_idle("basic", 200);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL basic_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL basic_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (pops != 3) $display("FAIL basic_pops: got %0d required 3", pops);
        else passed++;
        checks++;
        if (done_pos.size() != 1 || done_pos[0] != exp_done[0])
            $display("FAIL basic_done: got %0d pulses required 1 at byte %0d",
                     done_pos.size(), exp_done[0]);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt: got %0d required 1", frame_cnt);
        else passed++;
        checks++;
        if (first_en_cyc - first_pop_cyc != 2)
            $display("FAIL basic_latency: got %0d required 2", first_en_cyc - first_pop_cyc);
        else passed++;
        checks++;
        if (inv_bad != 0 || rd_bad != 0)
            $display("FAIL basic_invariants: got %0d/%0d violations required 0", inv_bad, rd_bad);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_random(4); queue_frame(4);
        fill_random(4); queue_frame(4);
        tx_en = 1'b1;
        wait_idle("b2b", 200);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL b2b_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL b2b_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] != IFG + 2)
            $display("FAIL b2b_gap: got %0d gaps (first %0d) required 1 of %0d",
                     gaps.size(), gaps.size() > 0 ? gaps[0] : -1, IFG + 2);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd2) $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt);
        else passed++;
    endtask

    task automatic test_random();
        int nf = 5;
        int words = 0;
        int bad_gap = 0;
        do_reset();
        for (int f = 0; f < nf; f++) begin
            int len = $urandom_range(1, 14);
            words += 1 + (len + 3) / 4;
            fill_random(len);
            queue_frame(len);
        end
        tx_en = 1'b1;
        wait_idle("rand", 600);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL rand_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL rand_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        foreach (gaps[i]) if (gaps[i] != IFG + 2) bad_gap++;
        checks++;
        if (gaps.size() != nf - 1 || bad_gap != 0)
            $display("FAIL rand_gaps: got %0d gaps, %0d wrong, required %0d of %0d",
                     gaps.size(), bad_gap, nf - 1, IFG + 2);
        else passed++;
        foreach (exp_done[i]) begin
            checks++;
            if (i >= done_pos.size() || done_pos[i] != exp_done[i])
                $display("FAIL rand_done%0d: got %0d required byte %0d", i,
                         i < done_pos.size() ? done_pos[i] : -1, exp_done[i]);
            else passed++;
        end
        checks++;
        if (pops != words) $display("FAIL rand_pops: got %0d required %0d", pops, words);
        else passed++;
        checks++;
        if (frame_cnt !== 16'(nf))
            $display("FAIL rand_frame_cnt: got %0d required %0d", frame_cnt, nf);
        else passed++;
        checks++;
        if (inv_bad != 0 || rd_bad != 0)
            $display("FAIL rand_invariants: got %0d/%0d violations required 0", inv_bad, rd_bad);
        else passed++;
    endtask

    task automatic test_underrun();
        logic [31:0] w0;
        int n = 0;
        do_reset();
        w0 = $urandom();
        fq.push_back({16'($urandom()), 16'd8});
        fq.push_back(w0);
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 8'(w0 >> (8 * k))});
        exp_q.push_back(9'h100);
        tx_en = 1'b1;
        while (und_cnt == 0 && n < 60) begin tick(); n++; end
        repeat (3) tick();
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL undr_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL undr_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (und_cnt != 1) $display("FAIL undr_pulse: got %0d required 1", und_cnt);
        else passed++;
        checks++;
        if (pops != 2) $display("FAIL undr_pops_before: got %0d required 2", pops);
        else passed++;
        fq.push_back($urandom());
        wait_idle("undr", 100);
        checks++;
        if (pops != 3 || obs.size() != exp_q.size())
            $display("FAIL undr_flush: got %0d pops %0d bytes required 3 pops %0d bytes",
                     pops, obs.size(), exp_q.size());
        else passed++;
        checks++;
        if (frame_cnt !== 16'd0 || done_pos.size() != 0)
            $display("FAIL undr_frame_cnt: got %0d/%0d required 0", frame_cnt, done_pos.size());
        else passed++;
        checks++;
        if (inv_bad != 0 || rd_bad != 0)
            $display("FAIL undr_invariants: got %0d/%0d violations required 0", inv_bad, rd_bad);
        else passed++;
    endtask

    task automatic test_len_err();
        do_reset();
        fill_random(1600); queue_frame(1600);
        fill_random(1519); queue_frame(1519);
        fill_random(4);    queue_frame(4);
        tx_en = 1'b1;
        wait_idle("lenerr", 2000);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL lenerr_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL lenerr_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (lerr_cnt != 2) $display("FAIL lenerr_pulse: got %0d required 2", lerr_cnt);
        else passed++;
        checks++;
        if (pops != 784) $display("FAIL lenerr_pops: got %0d required 784", pops);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL lenerr_frame_cnt: got %0d required 1", frame_cnt);
        else passed++;
    endtask

    task automatic test_zero_len();
        do_reset();
        queue_frame(0);
        fill_random(4); queue_frame(4);
        tx_en = 1'b1;
        wait_idle("zero", 200);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL zero_len_bytes: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL zero_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (pops != 3 || lerr_cnt != 0)
            $display("FAIL zero_pops: got %0d pops %0d len_err required 3/0", pops, lerr_cnt);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL zero_frame_cnt: got %0d required 1", frame_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        do_reset();
        fill_random(2); queue_frame(2);
        fill_random(8); queue_frame(8);
        tx_en = 1'b1;
        while (obs.size() < 21 && n < 100) begin tick(); n++; end
        checks++;
        if (frame_cnt !== 16'd1 || obs.size() != 21)
            $display("FAIL midrst_pre: got cnt %0d bytes %0d required 1/21", frame_cnt, obs.size());
        else passed++;
        reset_n = 1'b0;
        tick();
        checks++;
        if (MTxEn !== 1'b0 || MTxD !== 8'h00)
            $display("FAIL midrst_pins: got en=%b d=%h required 0/00", MTxEn, MTxD);
        else passed++;
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd0)
            $display("FAIL midrst_state: got busy=%b cnt=%0d required 0/0", busy, frame_cnt);
        else passed++;
        tx_en = 1'b0;
        fq.delete();
        tick(); tick();
        reset_n = 1'b1;
        clear_mon();
        fill_random(4); queue_frame(4);
        repeat (20) tick();
        checks++;
        if (pops != 0 || obs.size() != 0 || busy !== 1'b0)
            $display("FAIL txen_off: got %0d pops %0d bytes busy=%b required 0/0/0",
                     pops, obs.size(), busy);
        else passed++;
        tx_en = 1'b1;
        wait_idle("midrst", 200);
        checks++;
        if (obs.size() != exp_q.size())
            $display("FAIL midrst_len: got %0d bytes required %0d", obs.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i])
                $display("FAIL midrst_byte%0d: got %03h required %03h", i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL midrst_frame_cnt: got %0d required 1", frame_cnt);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_underrun();
        test_len_err();
        test_zero_len();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
